// File: rtl/alex_spi_receiver.sv
// Alex-board receiver for the Mercury -> Alex SPI control link.
// Oversamples SPI_data/SPI_clock and the two load strobes in the local
// clock domain, assembles 16-bit Tx and Rx words and decodes them into
// filter, antenna, attenuator, preamp and relay drives.
module alex_spi_receiver #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        SPI_data,
    input  logic        SPI_clock,
    input  logic        Tx_load_strobe,
    input  logic        Rx_load_strobe,
    output logic [15:0] tx_word,
    output logic [15:0] rx_word,
    output logic        tx_update,
    output logic        rx_update,
    output logic        frame_error,
    output logic [6:0]  LPF,
    output logic [2:0]  ANT,
    output logic        TR_relay,
    output logic        Tx_red_led,
    output logic [5:0]  HPF,
    output logic        _10dB_atten,
    output logic        _20dB_atten,
    output logic        Rx_1_out,
    output logic        Rx_1_in,
    output logic        Rx_2_in,
    output logic        Transverter,
    output logic        _6m_preamp,
    output logic        Rx_red_led,
    output logic        link_ok
);

    // Never fewer than two synchroniser flops, whatever the caller asks for.
    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,   // bit count 0
        S_SHIFT   = 2'd1,   // bit count 1..16
        S_OVERRUN = 2'd2    // bit count saturated at 17
    } state_t;

    logic [SS-1:0] r_data_sync;
    logic [SS-1:0] r_sclk_sync;
    logic [SS-1:0] r_txs_sync;
    logic [SS-1:0] r_rxs_sync;

    logic          r_sclk_d;
    logic          r_txs_d;
    logic          r_rxs_d;
    logic          r_data_d;
    logic          r_sclk_rise;
    logic          r_tx_rise;
    logic          r_rx_rise;

    state_t        r_state;
    state_t        w_state_next;
    logic [4:0]    r_bit_cnt;
    logic [4:0]    w_cnt_next;
    logic [TW-1:0] r_tmo;
    logic [TW-1:0] w_tmo_next;
    logic [15:0]   r_shreg;
    logic          w_shift;
    logic          w_tx_load;
    logic          w_rx_load;
    logic          w_ferr;

    logic [15:0]   r_tx_word;
    logic [15:0]   r_rx_word;
    logic          r_tx_update;
    logic          r_rx_update;
    logic          r_frame_error;

    // Synchronise every link input and register the rising-edge pulses;
    // data is delayed one extra flop so it lines up with the clock pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_data_sync <= '0;
            r_sclk_sync <= '0;
            r_txs_sync  <= '0;
            r_rxs_sync  <= '0;
            r_sclk_d    <= 1'b0;
            r_txs_d     <= 1'b0;
            r_rxs_d     <= 1'b0;
            r_data_d    <= 1'b0;
            r_sclk_rise <= 1'b0;
            r_tx_rise   <= 1'b0;
            r_rx_rise   <= 1'b0;
        end else begin
            r_data_sync <= {r_data_sync[SS-2:0], SPI_data};
            r_sclk_sync <= {r_sclk_sync[SS-2:0], SPI_clock};
            r_txs_sync  <= {r_txs_sync[SS-2:0],  Tx_load_strobe};
            r_rxs_sync  <= {r_rxs_sync[SS-2:0],  Rx_load_strobe};
            r_sclk_d    <= r_sclk_sync[SS-1];
            r_txs_d     <= r_txs_sync[SS-1];
            r_rxs_d     <= r_rxs_sync[SS-1];
            r_data_d    <= r_data_sync[SS-1];
            r_sclk_rise <= r_sclk_sync[SS-1] & ~r_sclk_d;
            r_tx_rise   <= r_txs_sync[SS-1]  & ~r_txs_d;
            r_rx_rise   <= r_rxs_sync[SS-1]  & ~r_rxs_d;
        end
    end

    // Frame FSM state register together with bit and idle counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_tmo     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_cnt_next;
            r_tmo     <= w_tmo_next;
        end
    end

    // Next-state logic: strobes beat a coincident SPI_clock edge, both
    // strobes together are an error, idle time mid-word drops the count.
    always_comb begin
        w_cnt_next   = r_bit_cnt;
        w_tmo_next   = r_tmo;
        w_state_next = r_state;
        w_shift      = 1'b0;
        w_tx_load    = 1'b0;
        w_rx_load    = 1'b0;
        w_ferr       = 1'b0;

        if (r_tx_rise && r_rx_rise) begin
            w_ferr     = 1'b1;
            w_cnt_next = '0;
            w_tmo_next = '0;
        end else if (r_tx_rise || r_rx_rise) begin
            if (r_bit_cnt == 5'd16) begin
                w_tx_load = r_tx_rise;
                w_rx_load = r_rx_rise;
            end else begin
                w_ferr = 1'b1;
            end
            w_cnt_next = '0;
            w_tmo_next = '0;
        end else if (r_sclk_rise) begin
            w_shift    = 1'b1;
            w_tmo_next = '0;
            if (r_state != S_OVERRUN) begin
                w_cnt_next = 5'(r_bit_cnt + 5'd1);
            end
        end else if (r_state != S_IDLE) begin
            if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                w_cnt_next = '0;
                w_tmo_next = '0;
            end else begin
                w_tmo_next = TW'(r_tmo + 1'b1);
            end
        end

        case (w_cnt_next)
            5'd0:    w_state_next = S_IDLE;
            5'd17:   w_state_next = S_OVERRUN;
            default: w_state_next = S_SHIFT;
        endcase
    end

    // Shift register, held words and one-clock status pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shreg       <= '0;
            r_tx_word     <= '0;
            r_rx_word     <= '0;
            r_tx_update   <= 1'b0;
            r_rx_update   <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            if (w_shift) begin
                r_shreg <= {r_shreg[14:0], r_data_d};
            end
            if (w_tx_load) begin
                r_tx_word <= r_shreg;
            end
            if (w_rx_load) begin
                r_rx_word <= r_shreg;
            end
            r_tx_update   <= w_tx_load;
            r_rx_update   <= w_rx_load;
            r_frame_error <= w_ferr;
        end
    end

    assign tx_word     = r_tx_word;
    assign rx_word     = r_rx_word;
    assign tx_update   = r_tx_update;
    assign rx_update   = r_rx_update;
    assign frame_error = r_frame_error;

    assign LPF         = {r_tx_word[15:13], r_tx_word[7:4]};
    assign ANT         = r_tx_word[10:8];
    assign TR_relay    = r_tx_word[11];
    assign Tx_red_led  = r_tx_word[12];

    assign HPF         = {r_rx_word[12], r_rx_word[6:4], r_rx_word[2:1]};
    assign _10dB_atten = r_rx_word[14];
    assign _20dB_atten = r_rx_word[13];
    assign Rx_1_out    = r_rx_word[11];
    assign Rx_1_in     = r_rx_word[10];
    assign Rx_2_in     = r_rx_word[9];
    assign Transverter = r_rx_word[8];
    assign _6m_preamp  = r_rx_word[3];
    assign Rx_red_led  = r_rx_word[15];

    assign link_ok     = r_tx_word[3] & r_rx_word[0];

endmodule

// File: tb/tb_alex_spi_receiver.sv
// Self-checking bench for alex_spi_receiver: directed link scenarios plus
// random frames, all checked against a bit-queue model of the link.
module tb_alex_spi_receiver;

    localparam int TIMEOUT = 4096;
    localparam int SYNC    = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        SPI_data = 1'b0;
    logic        SPI_clock = 1'b0;
    logic        Tx_load_strobe = 1'b0;
    logic        Rx_load_strobe = 1'b0;
    logic [15:0] tx_word, rx_word;
    logic        tx_update, rx_update, frame_error;
    logic [6:0]  LPF;
    logic [2:0]  ANT;
    logic        TR_relay, Tx_red_led;
    logic [5:0]  HPF;
    logic        _10dB_atten, _20dB_atten;
    logic        Rx_1_out, Rx_1_in, Rx_2_in, Transverter;
    logic        _6m_preamp, Rx_red_led, link_ok;

    alex_spi_receiver #(.TIMEOUT_CYCLES(TIMEOUT), .SYNC_STAGES(SYNC)) dut (
        .clock(clock), .reset(reset), .SPI_data(SPI_data), .SPI_clock(SPI_clock),
        .Tx_load_strobe(Tx_load_strobe), .Rx_load_strobe(Rx_load_strobe),
        .tx_word(tx_word), .rx_word(rx_word),
        .tx_update(tx_update), .rx_update(rx_update), .frame_error(frame_error),
        .LPF(LPF), .ANT(ANT), .TR_relay(TR_relay), .Tx_red_led(Tx_red_led),
        .HPF(HPF), ._10dB_atten(_10dB_atten), ._20dB_atten(_20dB_atten),
        .Rx_1_out(Rx_1_out), .Rx_1_in(Rx_1_in), .Rx_2_in(Rx_2_in),
        .Transverter(Transverter), ._6m_preamp(_6m_preamp),
        .Rx_red_led(Rx_red_led), .link_ok(link_ok)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: bits received since the last strobe/timeout/reset,
    // the held words, and expected pulse counts.
    bit          q[$];
    logic [15:0] m_tx = '0;
    logic [15:0] m_rx = '0;
    int          e_txu = 0, e_rxu = 0, e_ferr = 0;
    int          o_txu = 0, o_rxu = 0, o_ferr = 0;

    always @(negedge clock) begin
        if (tx_update)   o_txu++;
        if (rx_update)   o_rxu++;
        if (frame_error) o_ferr++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input bit b);
        SPI_data = b;
        tick(5);
        SPI_clock = 1'b1;
        tick(5);
        SPI_clock = 1'b0;
        q.push_back(b);
    endtask

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    // Idle with SPI_clock low; a partial word longer than the timeout is lost.
    task automatic idle(input int n);
        tick(n);
        if (n > TIMEOUT) q.delete();
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".tx_word"}, 32'(tx_word), 32'(m_tx));
        chk({tag, ".rx_word"}, 32'(rx_word), 32'(m_rx));
        chk({tag, ".LPF"}, 32'(LPF), 32'({m_tx[15:13], m_tx[7:4]}));
        chk({tag, ".ANT"}, 32'(ANT), 32'(m_tx[10:8]));
        chk({tag, ".TR_red"}, 32'({TR_relay, Tx_red_led}), 32'({m_tx[11], m_tx[12]}));
        chk({tag, ".HPF"}, 32'(HPF), 32'({m_rx[12], m_rx[6:4], m_rx[2:1]}));
        chk({tag, ".atten"}, 32'({_10dB_atten, _20dB_atten}), 32'({m_rx[14], m_rx[13]}));
        chk({tag, ".rxsel"}, 32'({Rx_1_out, Rx_1_in, Rx_2_in, Transverter}), 32'(m_rx[11:8]));
        chk({tag, ".pre_led"}, 32'({_6m_preamp, Rx_red_led}), 32'({m_rx[3], m_rx[15]}));
        chk({tag, ".link_ok"}, 32'(link_ok), 32'(m_tx[3] & m_rx[0]));
        chk({tag, ".n_txu"}, 32'(o_txu), 32'(e_txu));
        chk({tag, ".n_rxu"}, 32'(o_rxu), 32'(e_rxu));
        chk({tag, ".n_ferr"}, 32'(o_ferr), 32'(e_ferr));
    endtask

    // Raise strobe(s), optionally with a coincident SPI_clock edge (that bit
    // is never counted). The response pulse must appear exactly SYNC+2
    // clocks after the pin rises.
    task automatic strobe(input string tag, input bit do_tx, input bit do_rx, input bit coin);
        logic [15:0] w;
        bit          good;
        int          sel;
        good = (do_tx ^ do_rx) && (q.size() == 16);
        w = '0;
        foreach (q[i]) w = {w[14:0], q[i]};
        q.delete();
        if (good && do_tx) begin m_tx = w; e_txu++; sel = 0; end
        else if (good)     begin m_rx = w; e_rxu++; sel = 1; end
        else               begin e_ferr++; sel = 2; end

        Tx_load_strobe = do_tx;
        Rx_load_strobe = do_rx;
        if (coin) SPI_clock = 1'b1;
        repeat (SYNC + 1) @(posedge clock);
        @(negedge clock);
        chk({tag, ".early"}, 32'({tx_update, rx_update, frame_error}), 32'd0);
        @(posedge clock);
        @(negedge clock);
        chk({tag, ".pulse"}, 32'({tx_update, rx_update, frame_error}), 32'(3'b100 >> sel));
        @(posedge clock);
        #1;
        Tx_load_strobe = 1'b0;
        Rx_load_strobe = 1'b0;
        SPI_clock      = 1'b0;
        tick(6);
        check_outputs(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        @(negedge clock);
        check_outputs("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick(4);

        // Normal frame
        send_bits(32'hA5F8, 16);
        strobe("norm_tx", 1'b1, 1'b0, 1'b0);
        send_bits(32'h3C5D, 16);
        strobe("norm_rx", 1'b0, 1'b1, 1'b0);
        chk("norm.link_ok", 32'(link_ok), 32'd1);

        // Short frame then good frame
        send_bits(32'h1234, 15);
        strobe("short", 1'b1, 1'b0, 1'b0);
        send_bits(32'h5A3C, 16);
        strobe("after_short", 1'b1, 1'b0, 1'b0);

        // Overrun then good frame
        send_bits(32'hFACE_B00C, 20);
        strobe("overrun", 1'b0, 1'b1, 1'b0);
        send_bits(32'h0FF1, 16);
        strobe("after_over", 1'b0, 1'b1, 1'b0);

        // Timeout resync
        send_bits(32'h55, 7);
        idle(5000);
        send_bits(32'hC3E9, 16);
        strobe("timeout", 1'b1, 1'b0, 1'b0);

        // Both strobes together
        send_bits(32'h7777, 16);
        strobe("both", 1'b1, 1'b1, 1'b0);

        // Strobe coincident with the final SPI_clock edge
        send_bits(32'h2468, 15);
        SPI_data = 1'b1;
        tick(5);
        strobe("coincident", 1'b0, 1'b1, 1'b1);

        // Reset mid-word
        send_bits(32'hAB, 8);
        reset = 1'b1;
        q.delete();
        m_tx = '0;
        m_rx = '0;
        @(negedge clock);
        check_outputs("midreset");
        tick(3);
        reset = 1'b0;
        tick(4);
        send_bits(32'hCD, 8);
        strobe("post_reset", 1'b1, 1'b0, 1'b0);

        // Random frames
        for (int k = 0; k < 14; k++) begin
            logic [31:0] w;
            int          len;
            bit          to_tx;
            w     = $urandom;
            len   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(13, 19)) : 16;
            to_tx = 1'($urandom_range(0, 1));
            send_bits(w, len);
            strobe(to_tx ? "rnd_tx" : "rnd_rx", to_tx, !to_tx, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
